// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: data-operation codes used by the
// execute stage and the arbiter FSM state encoding.
package mem_arbiter_pkg;

    localparam logic [7:0] MEM_NOP = 8'd0;
    localparam logic [7:0] MEM_LB  = 8'd1;
    localparam logic [7:0] MEM_LW  = 8'd2;
    localparam logic [7:0] MEM_SB  = 8'd3;
    localparam logic [7:0] MEM_SW  = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    // Word-sized accesses must be word aligned; byte accesses never fault.
    function automatic logic is_word_op(input logic [7:0] op);
        return (op == MEM_LW) || (op == MEM_SW);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == MEM_SB) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane handling for one SRAM word: load extraction (sign-extended byte
// or full word) and store lane replication with byte enables.
module mem_lane
    import mem_arbiter_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  byte_sel,
    input  logic [31:0] store_data,
    input  logic [31:0] sram_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Select lanes and shape data according to the latched operation.
    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = sram_word;
        shifted   = sram_word >> {byte_sel, 3'b000};
        case (op)
            MEM_LB: begin
                load_data = {{24{shifted[7]}}, shifted[7:0]};
            end
            MEM_SB: begin
                be        = 4'b0001 << byte_sel;
                wdata     = {4{store_data[7:0]}};
                load_data = 32'd0;
            end
            MEM_SW: begin
                load_data = 32'd0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and data access.
// Data requests have fixed priority. Each access is IDLE -> BUSY -> DONE,
// with DONE acting as a one-cycle bus turnaround before the next grant.
// Handshake: a requester holds its request (if_req high / d_op non-NOP) with
// stable address and data until its one-cycle ack pulse; the arbiter latches
// everything at grant, so later request changes do not affect the access.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ACC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic [7:0]  d_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        sram_ce,
    output logic        sram_we,
    output logic [3:0]  sram_be,
    output logic [19:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        stall_o,
    output logic [1:0]  state_dbg
);

    localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

    arb_state_t  state;
    arb_state_t  next_state;
    logic [3:0]  cnt;
    logic [7:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        data_q;
    logic        err_q;

    logic        data_req;
    logic        grant;
    logic [7:0]  gnt_op;
    logic [31:0] gnt_addr;
    logic        gnt_mis;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    // A fetch is carried internally as a word load so the lane logic and the
    // alignment check treat it exactly like LW.
    always_comb begin
        data_req = (d_op != MEM_NOP);
        grant    = data_req || if_req;
        gnt_op   = data_req ? d_op : MEM_LW;
        gnt_addr = data_req ? d_addr : if_addr;
        gnt_mis  = is_word_op(gnt_op) && (gnt_addr[1:0] != 2'b00);
    end

    mem_lane u_lane (
        .op         (op_q),
        .byte_sel   (addr_q[1:0]),
        .store_data (wdata_q),
        .sram_word  (sram_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    // State register plus latched transaction and access counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            op_q    <= MEM_NOP;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            data_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        op_q    <= gnt_op;
                        addr_q  <= gnt_addr;
                        wdata_q <= d_wdata;
                        data_q  <= data_req;
                        err_q   <= gnt_mis;
                        rdata_q <= 32'd0;
                        cnt     <= CNT_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (cnt == 4'd0) begin
                        rdata_q <= lane_load;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state selection and all combinational outputs.
    always_comb begin
        next_state = state;
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = 4'b0000;
        sram_addr  = addr_q[21:2];
        sram_wdata = lane_wdata;
        if_ack     = 1'b0;
        d_ack      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    next_state = gnt_mis ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                sram_ce = 1'b1;
                sram_we = is_store_op(op_q);
                sram_be = lane_be;
                if (cnt == 4'd0) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if_ack     = !data_q;
                d_ack      = data_q;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        d_err     = d_ack && err_q;
        if_rdata  = if_ack ? rdata_q : 32'd0;
        d_rdata   = d_ack ? rdata_q : 32'd0;
        stall_o   = (if_req || data_req) && !(if_ack || d_ack);
        state_dbg = state;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random transactions
// checked against a word-array memory model updated by the access rules.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int ACC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic [7:0]  d_op;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        sram_ce;
    logic        sram_we;
    logic [3:0]  sram_be;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        stall_o;
    logic [1:0]  state_dbg;

    logic [31:0] sram_mem [0:255];
    logic [31:0] ref_mem  [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.ACC_CYCLES(ACC)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_rdata   (if_rdata),
        .d_op       (d_op),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_be    (sram_be),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .stall_o    (stall_o),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    assign sram_rdata = sram_mem[sram_addr[7:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; the SRAM model commits any write
    // strobed during the cycle that just ended.
    task automatic tick();
        @(negedge clk);
        if (sram_ce && sram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_be[b]) sram_mem[sram_addr[7:0]][8*b +: 8] = sram_wdata[8*b +: 8];
            end
        end
    endtask

    // One complete transaction from a single requester, issued at a falling
    // edge with the arbiter idle. Ends one cycle after the ack, arbiter idle.
    task automatic run_req(input logic is_data, input logic [7:0] op,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic perturb);
        logic        mis;
        logic        is_store;
        int          lat;
        int          idx;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        logic [7:0]  byt;
        logic        done;

        mis      = (!is_data || op == MEM_LW || op == MEM_SW) && (addr[1:0] != 2'b00);
        is_store = is_data && (op == MEM_SB || op == MEM_SW);
        lat      = mis ? 1 : ACC + 1;
        idx      = int'(addr[9:2]);
        byt      = ref_mem[idx][8*addr[1:0] +: 8];
        exp_rd   = mis ? 32'd0 : ref_mem[idx];
        if (is_data && op == MEM_LB) exp_rd = {{24{byt[7]}}, byt};
        exp_be   = 4'b1111;
        exp_wd   = wd;
        if (is_data && op == MEM_SB) begin
            exp_be = 4'b0001 << addr[1:0];
            exp_wd = {4{wd[7:0]}};
        end

        if (is_data) begin
            d_op = op; d_addr = addr; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        #1 chk("stall_on_request", stall_o, 1'b1);

        done = 1'b0;
        for (int n = 1; n <= lat && !done; n++) begin
            tick();
            if (n < lat) begin
                chk("ack_early", {d_ack, if_ack}, 2'b00);
                chk("stall_busy", stall_o, 1'b1);
                chk("sram_ce_busy", sram_ce, 1'b1);
                chk("sram_addr", sram_addr, addr[21:2]);
                chk("sram_we", sram_we, is_store);
                chk("sram_be", sram_be, exp_be);
                if (is_store) chk("sram_wdata", sram_wdata, exp_wd);
                if (perturb) begin
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                    if_addr = $urandom;
                end
            end else begin
                chk("d_ack", d_ack, is_data);
                chk("if_ack", if_ack, !is_data);
                chk("d_err", d_err, is_data && mis);
                chk("sram_ce_done", sram_ce, 1'b0);
                chk("stall_ack", stall_o, 1'b0);
                if (!is_data) chk("if_rdata", if_rdata, exp_rd);
                else if (!is_store && !mis) chk("d_rdata", d_rdata, exp_rd);
                done = 1'b1;
                d_op = MEM_NOP;
                if_req = 1'b0;
            end
        end

        if (is_store && !mis) begin
            if (op == MEM_SW) ref_mem[idx] = wd;
            else ref_mem[idx][8*addr[1:0] +: 8] = wd[7:0];
        end

        tick();
        chk("ack_single_pulse", {d_ack, if_ack}, 2'b00);
        chk("rdata_idle_zero", d_rdata | if_rdata, 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        int          kind;
        logic [31:0] a;

        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            sram_mem[i] = w;
            ref_mem[i]  = w;
        end
        sram_mem[4]  = 32'h12345678; ref_mem[4]  = 32'h12345678;
        sram_mem[64] = 32'h0080FF00; ref_mem[64] = 32'h0080FF00;

        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        d_op = MEM_NOP; d_addr = 32'd0; d_wdata = 32'd0;
        repeat (3) tick();
        chk("reset_acks", {if_ack, d_ack, d_err}, 3'b000);
        chk("reset_sram_ctl", {sram_ce, sram_we, sram_be}, 6'd0);
        chk("reset_sram_addr", sram_addr, 20'd0);
        chk("reset_rdata", if_rdata | d_rdata, 32'd0);
        chk("reset_state", state_dbg, ST_IDLE);
        chk("reset_stall", stall_o, 1'b0);
        rst = 1'b0;
        tick();

        // Aligned fetch of word 4.
        run_req(1'b0, MEM_NOP, 32'h00000010, 32'd0, 1'b0);

        // Fetch and LW raised together: data wins, fetch follows after turnaround.
        if_req = 1'b1; if_addr = 32'h00000010;
        d_op = MEM_LW; d_addr = 32'h00000020;
        for (int n = 1; n <= 7; n++) begin
            tick();
            chk("prio_d_ack", d_ack, n == 3);
            chk("prio_if_ack", if_ack, n == 7);
            chk("prio_stall", stall_o, !(n == 3 || n == 7));
            if (n == 3) begin
                chk("prio_d_rdata", d_rdata, ref_mem[8]);
                d_op = MEM_NOP;
            end
            if (n == 7) chk("prio_if_rdata", if_rdata, ref_mem[4]);
        end
        if_req = 1'b0;
        tick();

        // Byte store into the top lane, then read it back via LB and LW.
        run_req(1'b1, MEM_SB, 32'h00000103, 32'h000000AB, 1'b0);
        run_req(1'b1, MEM_LB, 32'h00000103, 32'd0, 1'b0);
        run_req(1'b1, MEM_LB, 32'h00000102, 32'd0, 1'b0);
        chk("lb_expected_const", {ref_mem[64][31:24], ref_mem[64][23:16]}, 16'hAB80);

        // Misaligned word load and fetch.
        run_req(1'b1, MEM_LW, 32'h00000006, 32'd0, 1'b0);
        run_req(1'b0, MEM_NOP, 32'h00000011, 32'd0, 1'b0);

        // Reset in the middle of an access.
        d_op = MEM_LW; d_addr = 32'h00000040;
        tick();
        chk("pre_reset_busy", sram_ce, 1'b1);
        rst = 1'b1; d_op = MEM_NOP;
        tick();
        chk("abort_sram_ce", sram_ce, 1'b0);
        chk("abort_acks", {d_ack, if_ack}, 2'b00);
        chk("abort_state", state_dbg, ST_IDLE);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("abort_no_ack", {d_ack, if_ack, sram_ce}, 3'b000);
        end
        run_req(1'b1, MEM_LW, 32'h00000040, 32'd0, 1'b0);

        // Random traffic with request fields perturbed mid-access.
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 4);
            a = 32'($urandom_range(0, 1023));
            if ((kind == 0 || kind == 2 || kind == 4) && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            case (kind)
                0: run_req(1'b0, MEM_NOP, a, 32'd0, 1'b1);
                1: run_req(1'b1, MEM_LB, a, $urandom, 1'b1);
                2: run_req(1'b1, MEM_LW, a, $urandom, 1'b1);
                3: run_req(1'b1, MEM_SB, a, $urandom, 1'b1);
                default: run_req(1'b1, MEM_SW, a, $urandom, 1'b1);
            endcase
        end

        // Final sweep: every word read back must match the model.
        for (int i = 0; i < 256; i += 17) begin
            run_req(1'b1, MEM_LW, 32'(i * 4), 32'd0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
